// File: rtl/alu.sv
// alu: two-operand ALU with a registered result and status flags.
//
// Ports:
//   clk       in   system clock, all state updates on the rising edge
//   rst_n     in   synchronous active-low reset
//   a, b      in   operands, WORDSIZE bits, unsigned or two's-complement
//   s         in   operation select: 00 add, 01 sub, 10 and, 11 or
//   y         out  registered result, WORDSIZE bits
//   carry     out  registered carry-out (add) or borrow (sub), 0 for logic ops
//   zero      out  registered, high when the result is all zeros
//   negative  out  registered copy of the result MSB
//   overflow  out  registered two's-complement overflow, 0 for logic ops
//
// A new operation is taken every cycle; its result and flags appear together
// one cycle later.
module alu #(
  parameter int WORDSIZE = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WORDSIZE-1:0] a,
  input  logic [WORDSIZE-1:0] b,
  input  logic [1:0]          s,
  output logic [WORDSIZE-1:0] y,
  output logic                carry,
  output logic                zero,
  output logic                negative,
  output logic                overflow
);

  localparam int MSB = WORDSIZE - 1;

  logic [WORDSIZE:0]   sum_ext;
  logic [WORDSIZE:0]   diff_ext;

  logic [WORDSIZE-1:0] y_d, y_q;
  logic                carry_d, carry_q;
  logic                zero_d, zero_q;
  logic                negative_d, negative_q;
  logic                overflow_d, overflow_q;

  always_comb begin
    // One extra bit: for the sum it is the carry-out, for the difference it
    // is set exactly when a < b unsigned (the borrow).
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};

    y_d        = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;

    unique case (s)
      2'b00: begin
        y_d        = sum_ext[MSB:0];
        carry_d    = sum_ext[WORDSIZE];
        overflow_d = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
      end
      2'b01: begin
        y_d        = diff_ext[MSB:0];
        carry_d    = diff_ext[WORDSIZE];
        overflow_d = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);
      end
      2'b10: y_d = a & b;
      2'b11: y_d = a | b;
      default: y_d = '0;
    endcase

    zero_d     = (y_d == '0);
    negative_d = y_d[MSB];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q        <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b1;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      y_q        <= y_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      overflow_q <= overflow_d;
    end
  end

  assign y        = y_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign negative = negative_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed, table-driven bench for alu at WORDSIZE = 32, with
// hand-written sequences around reset.
module tb_alu;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   s;
  logic [W-1:0] y;
  logic         carry;
  logic         zero;
  logic         negative;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   s;
    logic [W-1:0] ey;
    logic         ec;
    logic         ez;
    logic         en;
    logic         ev;
  } vec_t;

  vec_t vecs[$];

  alu #(.WORDSIZE(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .s        (s),
    .y        (y),
    .carry    (carry),
    .zero     (zero),
    .negative (negative),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_vec(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [1:0] vs, input logic [W-1:0] vy,
                         input logic vc, input logic vz, input logic vn,
                         input logic vv);
    vec_t v;
    v.a = va; v.b = vb; v.s = vs;
    v.ey = vy; v.ec = vc; v.ez = vz; v.en = vn; v.ev = vv;
    vecs.push_back(v);
  endtask

  // Compares {y, carry, zero, negative, overflow} against the expected tuple.
  task automatic check(input string name, input logic [W-1:0] ey,
                       input logic ec, input logic ez, input logic en,
                       input logic ev);
    logic [W+3:0] got;
    logic [W+3:0] exp;
    got = {y, carry, zero, negative, overflow};
    exp = {ey, ec, ez, en, ev};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got y=%h c=%b z=%b n=%b v=%b, want y=%h c=%b z=%b n=%b v=%b",
               name, y, carry, zero, negative, overflow, ey, ec, ez, en, ev);
    end
  endtask

  // Drive inputs on the falling edge, let one rising edge register them,
  // then sample just after that edge.
  task automatic drive_cycle(input logic r, input logic [W-1:0] va,
                             input logic [W-1:0] vb, input logic [1:0] vs);
    @(negedge clk);
    rst_n = r; a = va; b = vb; s = vs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; a = '0; b = '0; s = 2'b00;

    //        a             b             s      y             c     z     n     v
    add_vec(32'd1,        32'd1,        2'b00, 32'd2,        1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(32'd1,        32'd1,        2'b01, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(32'd1,        32'd1,        2'b10, 32'd1,        1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(32'd1,        32'd1,        2'b11, 32'd1,        1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(32'd1,        32'd0,        2'b00, 32'd1,        1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(32'd1,        32'd0,        2'b01, 32'd1,        1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(32'd1,        32'd0,        2'b10, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(32'd1,        32'd0,        2'b11, 32'd1,        1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(32'd0,        32'd1,        2'b01, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    add_vec(32'd0,        32'd1,        2'b00, 32'd1,        1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(32'd0,        32'd1,        2'b10, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(32'd0,        32'd1,        2'b11, 32'd1,        1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(32'd0,        32'd0,        2'b00, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(32'd0,        32'd0,        2'b01, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(32'd0,        32'd0,        2'b10, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(32'd0,        32'd0,        2'b11, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(32'hFFFFFFFF, 32'd1,        2'b00, 32'd0,        1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(32'h7FFFFFFF, 32'd1,        2'b00, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1);
    add_vec(32'h80000000, 32'd1,        2'b01, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    add_vec(32'h80000000, 32'h80000000, 2'b00, 32'd0,        1'b1, 1'b1, 1'b0, 1'b1);
    add_vec(32'h7FFFFFFF, 32'hFFFFFFFF, 2'b01, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b1);
    add_vec(32'h00000005, 32'h00000003, 2'b01, 32'd2,        1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(32'hF0F0F0F0, 32'hFF00FF00, 2'b10, 32'hF000F000, 1'b0, 1'b0, 1'b1, 1'b0);
    add_vec(32'h0F0F0F0F, 32'hF0F0F0F0, 2'b11, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    add_vec(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset held with busy inputs: outputs stay at reset values.
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, $urandom, $urandom, 2'($urandom_range(0, 3)));
      check($sformatf("reset_hold_%0d", i), '0, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Back-to-back vectors, one per cycle.
    foreach (vecs[i]) begin
      drive_cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].s);
      check($sformatf("vec_%0d", i), vecs[i].ey, vecs[i].ec, vecs[i].ez,
            vecs[i].en, vecs[i].ev);
    end

    // Mid-stream reset: a result with flags set, then one reset edge with
    // live inputs, then the first post-reset operation.
    drive_cycle(1'b1, 32'h7FFFFFFF, 32'd1, 2'b00);
    check("pre_reset", 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1);
    drive_cycle(1'b0, 32'hFFFFFFFF, 32'd1, 2'b00);
    check("mid_reset", '0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'd2, 32'd3, 2'b01);
    check("post_reset_first", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    drive_cycle(1'b1, 32'd7, 32'd1, 2'b00);
    check("post_reset_second", 32'd8, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
